frame_reader: RTL

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader_if.sv | 35 +++
 rtl/frame_reader.sv | 111 +++++++++++
 2 files changed

// File: rtl/frame_reader_if.sv
// Signal bundle between frame_reader and its video/frame-buffer/palette surroundings.
// The slave modport is the reader's own view; master is the surrounding system's view.
interface frame_reader_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs_in;
    logic        vs_in;
    logic        video_on_in;
    logic [17:0] fb_addr;
    logic [4:0]  fb_rdata;
    logic        pal_we;
    logic [4:0]  pal_addr;
    logic [23:0] pal_data;
    logic        swap_req;
    logic        swap_ack;
    logic        front_buf;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        hs_out;
    logic        vs_out;
    logic        video_on_out;

    modport slave (
        input  DrawX, DrawY, hs_in, vs_in, video_on_in, fb_rdata,
               pal_we, pal_addr, pal_data, swap_req,
        output fb_addr, swap_ack, front_buf, R, G, B, hs_out, vs_out, video_on_out
    );

    modport master (
        output DrawX, DrawY, hs_in, vs_in, video_on_in, fb_rdata,
               pal_we, pal_addr, pal_data, swap_req,
        input  fb_addr, swap_ack, front_buf, R, G, B, hs_out, vs_out, video_on_out
    );
endinterface

// File: rtl/frame_reader.sv
// Double-buffered 320x240 frame reader scaled 2x to 640x480, with a 32-entry palette
// and a swap FSM that only flips the front page at the start of vertical blanking.
module frame_reader #(
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter logic [4:0] BG_INDEX     = 5'h11,
    parameter logic [4:0] TRANSP_INDEX = 5'h15
) (
    input  logic            Clk,
    input  logic            Reset,
    frame_reader_if.slave   bus
);
    localparam logic [17:0] PAGE1_BASE = 18'd76800;

    typedef enum logic {IDLE, PENDING} swap_state_t;

    swap_state_t r_state;
    logic        r_front_buf;
    logic        r_swap_ack;
    logic [17:0] r_fb_addr;
    logic [2:0]  r_hs_dly;
    logic [2:0]  r_vs_dly;
    logic [2:0]  r_von_dly;
    logic [23:0] r_rgb;
    logic [23:0] r_palette [32];

    logic        w_visible;
    logic        w_swap_pt;
    logic [17:0] w_base;
    logic [17:0] w_row;
    logic [17:0] w_offset;
    logic [4:0]  w_index;
    logic [23:0] w_pal_rd;

    assign w_visible = (bus.DrawX < 10'(H_ACTIVE)) && (bus.DrawY < 10'(V_ACTIVE));
    assign w_swap_pt = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(V_ACTIVE));
    assign w_base    = r_front_buf ? PAGE1_BASE : 18'd0;
    // row*320 built as row*256 + row*64
    assign w_row     = {9'd0, bus.DrawY[9:1]};
    assign w_offset  = (w_row << 8) + (w_row << 6) + {9'd0, bus.DrawX[9:1]};

    assign w_index   = (bus.fb_rdata == TRANSP_INDEX) ? BG_INDEX : bus.fb_rdata;
    // A write landing on the entry being looked up wins over the stored value
    assign w_pal_rd  = (bus.pal_we && (bus.pal_addr == w_index)) ? bus.pal_data
                                                                 : r_palette[w_index];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) r_palette[i] <= '0;
        end else if (bus.pal_we) begin
            r_palette[bus.pal_addr] <= bus.pal_data;
        end
    end

    // Stage 1 address, stage 2 memory read, stage 3 colour; timing bits ride alongside
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fb_addr <= '0;
            r_hs_dly  <= '0;
            r_vs_dly  <= '0;
            r_von_dly <= '0;
            r_rgb     <= '0;
        end else begin
            r_fb_addr <= w_visible ? (w_base + w_offset) : w_base;
            r_hs_dly  <= {r_hs_dly[1:0],  bus.hs_in};
            r_vs_dly  <= {r_vs_dly[1:0],  bus.vs_in};
            r_von_dly <= {r_von_dly[1:0], bus.video_on_in};
            r_rgb     <= r_von_dly[1] ? w_pal_rd : 24'h0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_front_buf <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_swap_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.swap_req) begin
                        if (w_swap_pt) begin
                            r_front_buf <= ~r_front_buf;
                            r_swap_ack  <= 1'b1;
                        end else begin
                            r_state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (w_swap_pt) begin
                        r_front_buf <= ~r_front_buf;
                        r_swap_ack  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fb_addr      = r_fb_addr;
    assign bus.swap_ack     = r_swap_ack;
    assign bus.front_buf    = r_front_buf;
    assign bus.R            = r_rgb[23:16];
    assign bus.G            = r_rgb[15:8];
    assign bus.B            = r_rgb[7:0];
    assign bus.hs_out       = r_hs_dly[2];
    assign bus.vs_out       = r_vs_dly[2];
    assign bus.video_on_out = r_von_dly[2];
endmodule
